fpu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares one double-precision `fpu` instance (add/sub/mul/div, enable pulse in, ready/out back) between N requesters. Examples of requesters are the lag-generator product/sum stages and the echo-cancellation filter update. It latches a requester's operands, issues a one-cycle enable to the FPU, waits for completion (with a timeout), and returns the result with a per-requester done pulse.

---
 rtl/fpu_share_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_share_arbiter
//
// Purpose:
//   Time-shares one double-precision FPU (add/sub/mul/div) between N
//   requesters. A round-robin pointer chooses the next requester. The
//   arbiter latches that requester's operands into the fpu_* registers and
//   pulses fpu_enable for one cycle. It then waits for the FPU to complete,
//   or for a timeout to expire. Finally it returns the result with a
//   one-cycle done pulse to the requester it served.
//
// Ports:
//   clk, rst          operation clock and synchronous active-high reset
//   req[N]            request level per requester
//   req_op[3N]        fpu op per requester      (slice i = [3i+2:3i])
//   req_rmode[2N]     rounding mode per requester
//   req_opa/opb[64N]  operands per requester    (slice i = [64i+63:64i])
//   gnt[N]            one-hot grant, ISSUE through DONE
//   done[N]           one-cycle completion pulse to the served requester
//   result[64]        last result, updated in the done cycle and then held
//   timeout_err       pulses with done when the operation timed out
//   busy              high whenever the sequencer is not idle
//   fpu_enable        one-cycle start strobe to the FPU
//   fpu_op/rmode/opa/opb  registered FPU operands
//   fpu_out, fpu_ready    FPU result and ready level
// ----------------------------------------------------------------------------
module fpu_share_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [3*N-1:0]  req_op,
    input  logic [2*N-1:0]  req_rmode,
    input  logic [64*N-1:0] req_opa,
    input  logic [64*N-1:0] req_opb,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [63:0]     result,
    output logic            timeout_err,
    output logic            busy,
    output logic            fpu_enable,
    output logic [2:0]      fpu_op,
    output logic [1:0]      fpu_rmode,
    output logic [63:0]     fpu_opa,
    output logic [63:0]     fpu_opb,
    input  logic [63:0]     fpu_out,
    input  logic            fpu_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [IW:0]   L_N    = (IW + 1)'(N);
    localparam logic [IW-1:0] L_LAST = IW'(N - 1);
    localparam logic [WW-1:0] L_TMO  = WW'(TIMEOUT);
    localparam logic [63:0]   QNAN   = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [N-1:0]    r_gnt;
    logic            r_armed;
    logic            r_tmo;
    logic [WW-1:0]   r_wcnt;
    logic [63:0]     r_result;
    logic [2:0]      r_fpu_op;
    logic [1:0]      r_fpu_rmode;
    logic [63:0]     r_fpu_opa;
    logic [63:0]     r_fpu_opb;

    logic [N-1:0]    w_rot;
    logic [IW-1:0]   w_off;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_sel;
    logic [N-1:0]    w_sel_oh;
    logic [2:0]      w_sel_op;
    logic [1:0]      w_sel_rmode;
    logic [63:0]     w_sel_opa;
    logic [63:0]     w_sel_opb;
    logic            w_any_req;
    logic            w_ready_ok;
    logic            w_tmo_hit;

    // Round-robin pick: rotate req so that bit 0 is the requester at ptr.
    // The lowest set bit then gives the offset from ptr, and adding that
    // offset to ptr (mod N) gives the absolute index.
    assign w_any_req = |req;
    assign w_rot     = N'({req, req} >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sel = (w_sum >= L_N) ? IW'(w_sum - L_N) : IW'(w_sum);

    always_comb begin
        w_sel_oh    = '0;
        w_sel_op    = '0;
        w_sel_rmode = '0;
        w_sel_opa   = '0;
        w_sel_opb   = '0;
        for (int k = 0; k < N; k++) begin
            if (w_sel == IW'(k)) begin
                w_sel_oh[k] = 1'b1;
                w_sel_op    = req_op[3*k +: 3];
                w_sel_rmode = req_rmode[2*k +: 2];
                w_sel_opa   = req_opa[64*k +: 64];
                w_sel_opb   = req_opb[64*k +: 64];
            end
        end
    end

    // The FPU may still hold ready from the previous operation. Ready is
    // accepted only after it has been seen low at least once in WAIT.
    assign w_ready_ok = r_armed & fpu_ready;
    assign w_tmo_hit  = (r_wcnt == L_TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        fpu_enable  = 1'b0;
        done        = '0;
        timeout_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_enable  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_ready_ok || w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = r_gnt;
                timeout_err = r_tmo;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_gnt       <= '0;
            r_armed     <= 1'b0;
            r_tmo       <= 1'b0;
            r_wcnt      <= '0;
            r_result    <= '0;
            r_fpu_op    <= '0;
            r_fpu_rmode <= '0;
            r_fpu_opa   <= '0;
            r_fpu_opb   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt       <= w_sel_oh;
                        r_idx       <= w_sel;
                        r_fpu_op    <= w_sel_op;
                        r_fpu_rmode <= w_sel_rmode;
                        r_fpu_opa   <= w_sel_opa;
                        r_fpu_opb   <= w_sel_opb;
                    end
                end
                S_ISSUE: begin
                    r_armed <= 1'b0;
                    r_tmo   <= 1'b0;
                    r_wcnt  <= '0;
                end
                S_WAIT: begin
                    // The counter stops at TIMEOUT, so it cannot wrap.
                    if (!w_tmo_hit) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    if (!fpu_ready) begin
                        r_armed <= 1'b1;
                    end
                    // Ready takes priority over a timeout in the same cycle.
                    if (w_ready_ok) begin
                        r_result <= fpu_out;
                    end else if (w_tmo_hit) begin
                        r_result <= QNAN;
                        r_tmo    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_gnt <= '0;
                    r_ptr <= (r_idx == L_LAST) ? '0 : r_idx + 1'b1;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign result    = r_result;
    assign fpu_op    = r_fpu_op;
    assign fpu_rmode = r_fpu_rmode;
    assign fpu_opa   = r_fpu_opa;
    assign fpu_opb   = r_fpu_opb;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fpu_share_arbiter
//
// Directed bench for fpu_share_arbiter (N=4, TIMEOUT=10). A behavioural FPU
// model computes results with real arithmetic. Its ready level stays high
// after completion and drops one cycle after the enable strobe. Expected
// results are queued when a request is driven and are checked when done
// pulses.
// ----------------------------------------------------------------------------
module tb_fpu_share_arbiter;

    localparam int N   = 4;
    localparam int TMO = 10;
    localparam int LAT = 3;

    localparam logic [63:0] D0_25 = 64'h3FD0_0000_0000_0000;
    localparam logic [63:0] D0_5  = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] D0_75 = 64'h3FE8_0000_0000_0000;
    localparam logic [63:0] D1    = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D1_5  = 64'h3FF8_0000_0000_0000;
    localparam logic [63:0] D2    = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D3    = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D4    = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D5    = 64'h4014_0000_0000_0000;
    localparam logic [63:0] D8    = 64'h4020_0000_0000_0000;
    localparam logic [63:0] D9    = 64'h4022_0000_0000_0000;
    localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;

    typedef struct {
        int          idx;
        logic [63:0] res;
        logic        tmo;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_op;
    logic [2*N-1:0]  req_rmode;
    logic [64*N-1:0] req_opa;
    logic [64*N-1:0] req_opb;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [63:0]     result;
    logic            timeout_err;
    logic            busy;
    logic            fpu_enable;
    logic [2:0]      fpu_op;
    logic [1:0]      fpu_rmode;
    logic [63:0]     fpu_opa;
    logic [63:0]     fpu_opb;
    logic [63:0]     m_out;
    logic            m_ready;

    logic [63:0]     m_res;
    logic            m_drop;
    int              m_cnt;
    logic            never;

    exp_t            sb[$];
    exp_t            mon_e;
    int              n_cmp;
    int              n_bad;
    int              en_cnt;
    logic            mon_en;

    fpu_share_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_op      (req_op),
        .req_rmode   (req_rmode),
        .req_opa     (req_opa),
        .req_opb     (req_opb),
        .gnt         (gnt),
        .done        (done),
        .result      (result),
        .timeout_err (timeout_err),
        .busy        (busy),
        .fpu_enable  (fpu_enable),
        .fpu_op      (fpu_op),
        .fpu_rmode   (fpu_rmode),
        .fpu_opa     (fpu_opa),
        .fpu_opb     (fpu_opb),
        .fpu_out     (m_out),
        .fpu_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] fcalc(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        real ra;
        real rb;
        real rr;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        case (op)
            3'b000:  rr = ra + rb;
            3'b001:  rr = ra - rb;
            3'b010:  rr = ra * rb;
            default: rr = ra / rb;
        endcase
        return $realtobits(rr);
    endfunction

    // Behavioural FPU: ready stays high after completion and falls one
    // cycle after enable. The result follows LAT cycles later, unless the
    // model is in never-ready mode.
    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b0;
            m_out   <= '0;
            m_res   <= '0;
            m_drop  <= 1'b0;
            m_cnt   <= 0;
        end else if (fpu_enable) begin
            m_res  <= fcalc(fpu_op, fpu_opa, fpu_opb);
            m_drop <= 1'b1;
            m_cnt  <= LAT;
        end else if (m_drop) begin
            m_drop  <= 1'b0;
            m_ready <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !never) begin
                m_ready <= 1'b1;
                m_out   <= m_res;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [63:0] r, input logic t);
        exp_t e;
        e.idx = idx;
        e.res = r;
        e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic drive(input int i, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
        req_op[3*i +: 3]    = op;
        req_rmode[2*i +: 2] = 2'(i);
        req_opa[64*i +: 64] = a;
        req_opb[64*i +: 64] = b;
        req[i]              = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done === '0 && n < 60);
        n_cmp++;
        assert (done !== '0) else begin
            n_bad++;
            $error("FAIL %s: no done within %0d cycles, done=%b", tag, n, done);
        end
    endtask

    task automatic wait_en(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fpu_enable !== 1'b1 && n < 20);
        n_cmp++;
        assert (fpu_enable === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: no fpu_enable within %0d cycles, got %b", tag, n, fpu_enable);
        end
    endtask

    // Done monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (fpu_enable === 1'b1) en_cnt++;
            if (done !== '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_vec", 64'(done), 64'(1) << mon_e.idx);
                    chk("result", result, mon_e.res);
                    chk("timeout_err", 64'(timeout_err), 64'(mon_e.tmo));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int en0;
        n_cmp     = 0;
        n_bad     = 0;
        en_cnt    = 0;
        mon_en    = 1'b0;
        never     = 1'b0;
        rst       = 1'b1;
        req       = '0;
        req_op    = '0;
        req_rmode = '0;
        req_opa   = '0;
        req_opb   = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_enable", 64'(fpu_enable), 64'h0);
        chk("rst_result", result, 64'h0);
        chk("rst_timeout_err", 64'(timeout_err), 64'h0);
        chk("rst_opa", fpu_opa, 64'h0);
        rst = 1'b0;

        // Single requester 2: 1.5 * 2.0
        en0 = en_cnt;
        push_exp(2, D3, 1'b0);
        drive(2, 3'b010, D1_5, D2);
        @(negedge clk);
        chk("t1_gnt", 64'(gnt), 64'h4);
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_enable", 64'(fpu_enable), 64'h1);
        chk("t1_fpu_op", 64'(fpu_op), 64'h2);
        chk("t1_fpu_rmode", 64'(fpu_rmode), 64'h2);
        chk("t1_fpu_opa", fpu_opa, D1_5);
        chk("t1_fpu_opb", fpu_opb, D2);
        @(negedge clk);
        chk("t1_enable_low", 64'(fpu_enable), 64'h0);
        wait_done("t1_done");
        req = req & ~done;
        @(negedge clk);
        chk("t1_gnt_after", 64'(gnt), 64'h0);
        chk("t1_busy_after", 64'(busy), 64'h0);
        chk("t1_result_held", result, D3);
        chk("t1_enable_pulses", 64'(en_cnt - en0), 64'h1);

        // All four requesters together after reset: service order 0,1,2,3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t2_rst_result", result, 64'h0);
        push_exp(0, D3, 1'b0);
        push_exp(1, D2, 1'b0);
        push_exp(2, D8, 1'b0);
        push_exp(3, D4, 1'b0);
        drive(0, 3'b000, D1, D2);
        drive(1, 3'b001, D3, D1);
        drive(2, 3'b010, D2, D4);
        drive(3, 3'b011, D8, D2);
        for (int k = 0; k < 4; k++) begin
            wait_done("t2_done");
            req = req & ~done;
        end

        // Requester 1 held high, requester 3 toggling: 1,3,1,3
        push_exp(1, D2, 1'b0);
        push_exp(3, D0_75, 1'b0);
        push_exp(1, D2, 1'b0);
        push_exp(3, D0_75, 1'b0);
        drive(1, 3'b001, D5, D3);
        drive(3, 3'b000, D0_5, D0_25);
        wait_done("t3_a");
        wait_done("t3_b");
        req[3] = 1'b0;
        @(negedge clk);
        req[3] = 1'b1;
        wait_done("t3_c");
        req[1] = 1'b0;
        wait_done("t3_d");
        req[3] = 1'b0;

        // FPU ready still high from the previous op: no premature done
        push_exp(0, D9, 1'b0);
        drive(0, 3'b010, D3, D3);
        wait_en("t4_en");
        @(negedge clk);
        chk("t4_w1_no_done", 64'(done), 64'h0);
        @(negedge clk);
        chk("t4_w2_no_done", 64'(done), 64'h0);
        wait_done("t4_done");
        req[0] = 1'b0;

        // FPU never ready: timeout after TMO+1 WAIT cycles, then normal op
        never = 1'b1;
        push_exp(2, QNAN, 1'b1);
        drive(2, 3'b000, D1, D1);
        wait_en("t5_en");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done === '0 && n < 40);
        chk("t5_latency", 64'(n), 64'(TMO + 2));
        req[2] = 1'b0;
        never  = 1'b0;
        push_exp(1, D0_25, 1'b0);
        drive(1, 3'b011, D1, D4);
        wait_done("t5_next_done");
        req[1] = 1'b0;

        // Reset in the middle of WAIT: no done, everything cleared
        drive(3, 3'b000, D1, D1);
        wait_en("t6_en");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t6_gnt", 64'(gnt), 64'h0);
        chk("t6_done", 64'(done), 64'h0);
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_enable", 64'(fpu_enable), 64'h0);
        chk("t6_timeout_err", 64'(timeout_err), 64'h0);
        chk("t6_result", result, 64'h0);
        chk("t6_fpu_op", 64'(fpu_op), 64'h0);
        chk("t6_fpu_rmode", 64'(fpu_rmode), 64'h0);
        chk("t6_fpu_opa", fpu_opa, 64'h0);
        chk("t6_fpu_opb", fpu_opb, 64'h0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6_idle_busy", 64'(busy), 64'h0);
        push_exp(0, D4, 1'b0);
        drive(0, 3'b000, D2, D2);
        @(negedge clk);
        chk("t6_gnt0", 64'(gnt), 64'h1);
        wait_done("t6_done0");
        req[0] = 1'b0;
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
